// File: rtl/freq_div_pkg.sv
// Shared divide ratios for the freq_div clock divider and its divide-by-3 stage.
// Counter widths are derived from the ratios so the RTL tracks them automatically.
package freq_div_pkg;

  localparam int DIV2 = 2;
  localparam int DIV3 = 3;
  localparam int DIV4 = 4;

  localparam int C4_W = $clog2(DIV4);
  localparam int C3_W = $clog2(DIV3);

  // Last value of the modulo-3 counter before it wraps back to zero.
  localparam logic [C3_W-1:0] C3_WRAP = C3_W'(DIV3 - 1);

endpackage

// File: rtl/div3_half_duty.sv
// Divide-by-3 stage: modulo-3 counter, registered pulse p3 and optional half-cycle stretch n3.
// With HALF_DUTY=1 the output is p3 OR n3; the two flops change on opposite clock edges.
module div3_half_duty
  import freq_div_pkg::*;
#(
  parameter bit HALF_DUTY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  logic [C3_W-1:0] c3;
  logic [C3_W-1:0] c3_next;
  logic            p3;

  always_comb begin
    c3_next = c3 + 2'd1;
    if (c3 == C3_WRAP) begin
      c3_next = '0;
    end
  end

  // p3 is decoded from the next count so the output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c3 <= '0;
      p3 <= 1'b0;
    end else begin
      c3 <= c3_next;
      p3 <= (c3_next == 2'd1);
    end
  end

  generate
    if (HALF_DUTY) begin : g_half
      logic n3;

      always_ff @(negedge clk) begin
        if (!rst) begin
          n3 <= 1'b0;
        end else begin
          n3 <= p3;
        end
      end

      assign clk_out = p3 | n3;
    end else begin : g_third
      assign clk_out = p3;
    end
  endgenerate

endmodule

// File: rtl/freq_div.sv
// Phase-aligned divide-by-2, -3 and -4 clock generator from a single source clock.
// Divide-by-2 and -4 are the bits of a free-running 2-bit counter; divide-by-3 is a sub-module.
module freq_div
  import freq_div_pkg::*;
#(
  parameter bit DIV3_HALF_DUTY = 1'b1
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out_2x,
  output logic clk_out_3x,
  output logic clk_out_4x
);

  logic [C4_W-1:0] c4;

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      c4 <= '0;
    end else begin
      c4 <= c4 + 2'd1;
    end
  end

  // Each power-of-two output is the counter bit whose period matches its ratio.
  assign clk_out_2x = c4[$clog2(DIV2)-1];
  assign clk_out_4x = c4[$clog2(DIV4)-1];

  div3_half_duty #(
    .HALF_DUTY(DIV3_HALF_DUTY)
  ) u_div3 (
    .clk    (clk_in),
    .rst    (rst),
    .clk_out(clk_out_3x)
  );

endmodule

// File: tb/tb_freq_div.sv
// Self-checking bench for freq_div: both duty variants run side by side against a
// model driven by the count of rising edges since reset release.
module tb_freq_div;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  logic out2_h, out3_h, out4_h;
  logic out2_t, out3_t, out4_t;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  freq_div #(.DIV3_HALF_DUTY(1'b1)) dut_half (
    .clk_in    (clk_in),
    .rst       (rst),
    .clk_out_2x(out2_h),
    .clk_out_3x(out3_h),
    .clk_out_4x(out4_h)
  );

  freq_div #(.DIV3_HALF_DUTY(1'b0)) dut_third (
    .clk_in    (clk_in),
    .rst       (rst),
    .clk_out_2x(out2_t),
    .clk_out_3x(out3_t),
    .clk_out_4x(out4_t)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [5:0] observed();
    return {out2_h, out4_h, out3_h, out2_t, out4_t, out3_t};
  endfunction

  // k rising edges after release: 2x = k mod 2, 4x = (k mod 4) >= 2; the divide-by-3
  // output rises on edges with k mod 3 == 1 and stays high 1.5 (50%) or 1 (33%) cycles.
  function automatic logic [5:0] expected(input bit late);
    int  ph;
    logic e2, e4, e50, e33;
    ph  = k % 3;
    e2  = (k % 2) == 1;
    e4  = (k % 4) >= 2;
    e33 = (ph == 1);
    e50 = (ph == 1) || ((ph == 2) && !late);
    return {e2, e4, e50, e2, e4, e33};
  endfunction

  task automatic tick_rise();
    @(posedge clk_in);
    if (!rst) k = 0;
    else      k = k + 1;
    #1;
  endtask

  task automatic tick_fall();
    @(negedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    k = 0;
    n = 2 + $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      tick_rise();
      checks++;
      if (observed() !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_rise cycle=%0d got=%b want=%b", i, observed(), 6'b0);
      end
      tick_fall();
      checks++;
      if (observed() !== 6'b0) begin
        failures++;
        $display("[TB] FAIL reset_fall cycle=%0d got=%b want=%b", i, observed(), 6'b0);
      end
    end
  endtask

  task automatic test_steady();
    for (int i = 0; i < 25; i++) begin
      tick_rise();
      checks++;
      if (observed() !== expected(1'b0)) begin
        failures++;
        $display("[TB] FAIL steady_rise k=%0d got=%b want=%b", k, observed(), expected(1'b0));
      end
      if (i == 0) rst = 1'b1;
      tick_fall();
      checks++;
      if (observed() !== expected(1'b1)) begin
        failures++;
        $display("[TB] FAIL steady_fall k=%0d got=%b want=%b", k, observed(), expected(1'b1));
      end
    end
  endtask

  task automatic test_duty();
    int cnt [6];
    int want [6];
    logic [5:0] s;
    want = '{12, 12, 12, 12, 12, 8};
    for (int j = 0; j < 6; j++) cnt[j] = 0;
    for (int i = 0; i < 12; i++) begin
      tick_rise();
      s = observed();
      for (int j = 0; j < 6; j++) cnt[j] += int'(s[5-j]);
      tick_fall();
      s = observed();
      for (int j = 0; j < 6; j++) cnt[j] += int'(s[5-j]);
    end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (cnt[j] != want[j]) begin
        failures++;
        $display("[TB] FAIL duty_halfcycles output=%0d got=%0d want=%0d", j, cnt[j], want[j]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit asserted;
    bit released;
    int hold;
    asserted = 1'b0;
    released = 1'b0;
    hold     = 0;
    rst      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick_rise();
      checks++;
      if (observed() !== expected(1'b0)) begin
        failures++;
        $display("[TB] FAIL midreset_rise k=%0d got=%b want=%b", k, observed(), expected(1'b0));
      end
      if (!rst && !asserted && i >= 1) begin
        rst = 1'b1;
      end else if (rst && !asserted && k == 7) begin
        checks++;
        if ({out3_h, out3_t} !== 2'b11) begin
          failures++;
          $display("[TB] FAIL midreset_high_at_7 got=%b want=%b", {out3_h, out3_t}, 2'b11);
        end
        rst      = 1'b0;
        asserted = 1'b1;
      end else if (asserted && !released) begin
        hold++;
        if (hold == 2) begin
          rst      = 1'b1;
          released = 1'b1;
        end
      end
      tick_fall();
      checks++;
      if (observed() !== expected(1'b1)) begin
        failures++;
        $display("[TB] FAIL midreset_fall k=%0d got=%b want=%b", k, observed(), expected(1'b1));
      end
    end
  endtask

  task automatic test_random_resets();
    int run_len;
    int rst_len;
    for (int r = 0; r < 6; r++) begin
      run_len = $urandom_range(1, 20);
      rst_len = $urandom_range(1, 3);
      for (int i = 0; i < run_len + rst_len; i++) begin
        tick_rise();
        checks++;
        if (observed() !== expected(1'b0)) begin
          failures++;
          $display("[TB] FAIL random_rise round=%0d k=%0d got=%b want=%b", r, k, observed(), expected(1'b0));
        end
        if (i == run_len - 1)               rst = 1'b0;
        else if (i == run_len + rst_len - 1) rst = 1'b1;
        tick_fall();
        checks++;
        if (observed() !== expected(1'b1)) begin
          failures++;
          $display("[TB] FAIL random_fall round=%0d k=%0d got=%b want=%b", r, k, observed(), expected(1'b1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty();
    test_mid_reset();
    test_random_resets();
    test_duty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
